// File: rtl/mem_load_unit_pkg.sv
// Shared load encodings, size and FSM state types for the load unit.
package mem_load_unit_pkg;

  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LD      = 3'b011;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_LWU     = 3'b110;
  localparam logic [2:0] F3_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    SZ_BYTE   = 2'd0,
    SZ_HALF   = 2'd1,
    SZ_WORD   = 2'd2,
    SZ_DOUBLE = 2'd3
  } load_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic load_size_e size_of(input logic [2:0] f3);
    return load_size_e'(f3[1:0]);
  endfunction

  // Illegal encodings are screened out by the caller before this is consulted.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
    case (size_of(f3))
      SZ_HALF:   return off[0];
      SZ_WORD:   return |off[1:0];
      SZ_DOUBLE: return |off;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_unit_load_extender.sv
// Moves the addressed bytes of a 64-bit beat down to bit 0 and sign/zero-extends per funct3.
module load_extender
  import mem_load_unit_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [63:0] data_o
);

  logic [63:0] shifted;

  assign shifted = rdata_i >> {offset_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_LB:   data_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_LH:   data_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_LW:   data_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_LBU:  data_o = {56'd0, shifted[7:0]};
      F3_LHU:  data_o = {48'd0, shifted[15:0]};
      F3_LWU:  data_o = {32'd0, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/mem_load_unit.sv
// Single-outstanding load unit: aligned 8-byte read, lane shift/extend, registered writeback.
module mem_load_unit
  import mem_load_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load_req,
  output logic                  o_load_ready,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [2:0]            i_funct3,
  input  logic [4:0]            i_rd,
  output logic                  o_mem_read_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_gnt,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [4:0]            o_rsp_rd,
  output logic                  o_misaligned,
  output logic                  o_illegal
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [2:0]            f3_q, f3_d;
  logic [4:0]            rd_q, rd_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  mis_q, mis_d;
  logic                  ill_q, ill_d;
  logic [DATA_WIDTH-1:0] ext_data;

  load_extender u_load_extender (
    .rdata_i  (i_mem_rdata),
    .offset_i (addr_q[2:0]),
    .funct3_i (f3_q),
    .data_o   (ext_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      f3_q    <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    rd_d    = rd_q;
    data_d  = data_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    case (state_q)
      ST_IDLE: begin
        if (i_load_req) begin
          addr_d = i_addr;
          f3_d   = i_funct3;
          rd_d   = i_rd;
          ill_d  = (i_funct3 == F3_ILLEGAL);
          mis_d  = !ill_d && is_misaligned(i_funct3, i_addr[2:0]);
          // Faulting loads skip memory and answer with zero data.
          if (ill_d || mis_d) begin
            data_d  = '0;
            state_d = ST_RESP;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (i_mem_gnt) begin
          if (i_mem_rvalid) begin
            data_d  = ext_data;
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (i_mem_rvalid) begin
          data_d  = ext_data;
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_load_ready   = (state_q == ST_IDLE);
  assign o_mem_read_req = (state_q == ST_REQ);
  assign o_mem_addr     = {addr_q[ADDR_WIDTH-1:3], 3'b000};
  assign o_rsp_valid    = (state_q == ST_RESP);
  assign o_rsp_data     = data_q;
  assign o_rsp_rd       = rd_q;
  assign o_misaligned   = mis_q;
  assign o_illegal      = ill_q;

endmodule
